// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared FSM encoding and default bus widths for the DCPU16 memory bus blocks.
package dcpu16_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
endpackage

// File: rtl/dcpu16_arb_pick.sv
// dcpu16_arb_pick: combinational grant selector, fixed priority or round-robin from ptr.
module dcpu16_arb_pick #(
  parameter int NCH = 3,
  parameter int RR  = 0,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);
  logic [IW-1:0] k;
  always_comb begin
    idx = '0;
    gnt = '0;
    k = '0;
    // Walk from the lowest search offset last so the first active channel wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      k = RR != 0 ? IW'((int'(ptr) + i) % NCH) : IW'(i);
      if (req[k]) begin
        idx = k;
        gnt = '0;
        gnt[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dcpu16_mbus_arb.sv
// dcpu16_mbus_arb: N-channel arbiter onto one simplified-Wishbone master with watchdog and stall output.
module dcpu16_mbus_arb import dcpu16_pkg::*; #(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int NCH = 3,
  parameter int RR  = 0,
  parameter int TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_stb,
  input  logic [NCH-1:0]    req_wre,
  input  logic [NCH*AW-1:0] req_adr,
  input  logic [NCH*DW-1:0] req_dto,
  output logic [NCH-1:0]    req_ack,
  output logic [NCH-1:0]    req_err,
  output logic [DW-1:0]     req_dti,
  output logic              ena,
  output logic [AW-1:0]     m_adr,
  output logic [DW-1:0]     m_dto,
  output logic              m_stb,
  output logic              m_wre,
  input  logic [DW-1:0]     m_dti,
  input  logic              m_ack
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = TMO > 0 ? $clog2(TMO + 1) : 1;
  state_t st, st_nx;
  logic [IW-1:0] ptr, pick_idx;
  logic [NCH-1:0] pick_gnt, oh;
  logic [CW-1:0] cnt;
  logic tmo_hit;
  dcpu16_arb_pick #(.NCH(NCH), .RR(RR), .IW(IW)) u_pick (
    .req(req_stb),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  // Timeout fires on the BUSY cycle whose increment would reach TMO; an ack in that cycle wins.
  assign tmo_hit = TMO != 0 && int'(cnt) == TMO - 1;
  assign ena = ~|(req_stb & ~(req_ack | req_err));
  always_comb begin
    st_nx = st == IDLE ? (|req_stb ? BUSY : IDLE) :
            st == BUSY ? (m_ack || tmo_hit ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      oh <= '0;
      cnt <= '0;
      m_adr <= '0;
      m_dto <= '0;
      m_wre <= 1'b0;
      m_stb <= 1'b0;
      req_ack <= '0;
      req_err <= '0;
      req_dti <= '0;
    end else begin
      st <= st_nx;
      req_ack <= '0;
      req_err <= '0;
      if (st == IDLE && |req_stb) begin
        oh <= pick_gnt;
        m_adr <= req_adr[pick_idx*AW +: AW];
        m_dto <= req_dto[pick_idx*DW +: DW];
        m_wre <= req_wre[pick_idx];
        m_stb <= 1'b1;
        cnt <= '0;
        ptr <= int'(pick_idx) == NCH - 1 ? '0 : pick_idx + 1'b1;
      end
      if (st == BUSY) begin
        cnt <= &cnt ? cnt : cnt + 1'b1;
        if (m_ack) begin
          m_stb <= 1'b0;
          req_ack <= oh;
          if (!m_wre) req_dti <= m_dti;
        end else if (tmo_hit) begin
          m_stb <= 1'b0;
          req_err <= oh;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// tb_dcpu16_mbus_arb: fixed-priority and round-robin arbiters driven side by side against a transaction-level model.
module tb_dcpu16_mbus_arb;
  localparam int TMO = 15;
  logic clk, rst;
  logic [2:0] stb[2];
  logic ack_in[2];
  logic [2:0] dack[2], derr[2];
  logic [15:0] dti[2], madr[2], mdto[2];
  logic mstb[2], mwre[2], ena[2];
  logic [15:0] adr_a[3], dto_a[3], sdata;
  logic [2:0] wre_v;
  logic [47:0] req_adr, req_dto;
  int pend[2][3], wc[2], ws, acode[2], ecode[2], scyc[2];
  int total = 0, pass = 0;
  bit run = 0, stray = 0;
  int act[2], waited[2], mptr[2];
  bit cool[2], estb[2], ewre[2];
  logic [2:0] eack[2], eerr[2];
  logic [15:0] edti[2], eadr[2], edto[2];

  assign req_adr = {adr_a[2], adr_a[1], adr_a[0]};
  assign req_dto = {dto_a[2], dto_a[1], dto_a[0]};

  dcpu16_mbus_arb #(.NCH(3), .RR(0), .TMO(TMO)) u_fix (
    .clk(clk), .rst(rst), .req_stb(stb[0]), .req_wre(wre_v), .req_adr(req_adr), .req_dto(req_dto),
    .req_ack(dack[0]), .req_err(derr[0]), .req_dti(dti[0]), .ena(ena[0]), .m_adr(madr[0]),
    .m_dto(mdto[0]), .m_stb(mstb[0]), .m_wre(mwre[0]), .m_dti(sdata), .m_ack(ack_in[0])
  );
  dcpu16_mbus_arb #(.NCH(3), .RR(1), .TMO(TMO)) u_rr (
    .clk(clk), .rst(rst), .req_stb(stb[1]), .req_wre(wre_v), .req_adr(req_adr), .req_dto(req_dto),
    .req_ack(dack[1]), .req_err(derr[1]), .req_dti(dti[1]), .ena(ena[1]), .m_adr(madr[1]),
    .m_dto(mdto[1]), .m_stb(mstb[1]), .m_wre(mwre[1]), .m_dti(sdata), .m_ack(ack_in[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int d, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, d, a, e, $time);
  endtask

  // Model: one transaction at a time, one dead cycle after each completion.
  initial forever begin
    int w, c;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] = -1; cool[d] = 0; mptr[d] = 0; eack[d] = 0; eerr[d] = 0;
        edti[d] = 0; eadr[d] = 0; edto[d] = 0; estb[d] = 0; ewre[d] = 0;
      end else begin
        eack[d] = 0;
        eerr[d] = 0;
        if (cool[d]) cool[d] = 0;
        else if (act[d] < 0) begin
          w = -1;
          for (int k = 0; k < 3; k++) begin
            c = d == 1 ? (mptr[d] + k) % 3 : k;
            if (w < 0 && stb[d][c]) w = c;
          end
          if (w >= 0) begin
            act[d] = w; waited[d] = 0; eadr[d] = adr_a[w]; edto[d] = dto_a[w];
            ewre[d] = wre_v[w]; estb[d] = 1; mptr[d] = (w + 1) % 3;
          end
        end else if (ack_in[d]) begin
          eack[d][act[d]] = 1'b1;
          if (!ewre[d]) edti[d] = sdata;
          estb[d] = 0; act[d] = -1; cool[d] = 1;
        end else begin
          waited[d]++;
          if (waited[d] == TMO) begin
            eerr[d][act[d]] = 1'b1;
            estb[d] = 0; act[d] = -1; cool[d] = 1;
          end
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (run) begin
        chk("m_stb", d, 64'(mstb[d]), 64'(estb[d]));
        chk("m_adr", d, 64'(madr[d]), 64'(eadr[d]));
        chk("m_dto", d, 64'(mdto[d]), 64'(edto[d]));
        chk("m_wre", d, 64'(mwre[d]), 64'(ewre[d]));
        chk("req_ack", d, 64'(dack[d]), 64'(eack[d]));
        chk("req_err", d, 64'(derr[d]), 64'(eerr[d]));
        chk("req_dti", d, 64'(dti[d]), 64'(edti[d]));
        chk("ena", d, 64'(ena[d]), 64'(~|(stb[d] & ~(eack[d] | eerr[d]))));
      end
      for (int i = 0; i < 3; i++) begin
        if (dack[d][i] === 1'b1) acode[d] = acode[d] * 10 + i + 1;
        if (derr[d][i] === 1'b1) ecode[d] = ecode[d] * 10 + i + 1;
      end
      if (mstb[d] === 1'b1) scyc[d]++;
    end
  end

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        if ((dack[d][i] || derr[d][i]) && pend[d][i] > 0) pend[d][i]--;
        stb[d][i] = pend[d][i] > 0;
      end
      if (stray) ack_in[d] = 1'b1;
      else if (mstb[d]) begin
        ack_in[d] = ws >= 0 && wc[d] == ws;
        wc[d]++;
      end else begin
        ack_in[d] = 1'b0;
        wc[d] = 0;
      end
    end
  endtask

  task automatic req(int ch, int n);
    pend[0][ch] = n;
    pend[1][ch] = n;
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      acode[d] = 0; ecode[d] = 0; scyc[d] = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    bit busy;
    do begin
      step();
      n++;
      busy = mstb[0] || mstb[1];
      for (int d = 0; d < 2; d++) for (int i = 0; i < 3; i++) if (pend[d][i] > 0) busy = 1;
    end while (n < 400 && busy);
    if (busy) begin
      total++;
      $display("FAIL wait_idle transfers still pending after %0d cycles", n);
    end
  endtask

  initial begin
    rst = 1; ws = 0; sdata = 0; wre_v = 0;
    for (int i = 0; i < 3; i++) begin
      adr_a[i] = 0; dto_a[i] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      stb[d] = 0; ack_in[d] = 0; wc[d] = 0;
      for (int i = 0; i < 3; i++) pend[d][i] = 0;
    end
    clr();
    @(negedge clk);
    run = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_m_stb", 0, 64'(mstb[0]), 0);
    chk("rst_dti", 1, 64'(dti[1]), 0);
    chk("rst_ena", 0, 64'(ena[0]), 1);
    // single zero-wait read on ch1
    adr_a[1] = 16'h1234; sdata = 16'hBEEF; clr(); req(1, 1); wait_idle();
    chk("rd_dti", 0, 64'(dti[0]), 64'hBEEF);
    chk("rd_acks", 0, 64'(acode[0]), 2);
    chk("rd_stb_cycles", 1, 64'(scyc[1]), 1);
    // three-way contention
    adr_a[0] = 16'h1000; adr_a[2] = 16'h3000; dto_a[2] = 16'h0777; sdata = 16'hA5A5;
    clr(); req(0, 1); req(1, 1); req(2, 1); wait_idle();
    chk("fix_order", 0, 64'(acode[0]), 123);
    chk("rr_order", 1, 64'(acode[1]), 312);
    clr(); req(2, 1); wait_idle();
    chk("rr_single", 1, 64'(acode[1]), 3);
    // ch0 held for two transfers alongside ch2
    clr(); req(0, 2); req(2, 2); wait_idle();
    chk("fix_hold", 0, 64'(acode[0]), 1133);
    chk("rr_hold", 1, 64'(acode[1]), 1313);
    // write with three wait states
    wre_v = 3'b001; adr_a[0] = 16'h8000; dto_a[0] = 16'h00FF; sdata = 16'h5555; ws = 3;
    clr(); req(0, 1); wait_idle();
    chk("wr_dti_kept", 0, 64'(dti[0]), 64'hA5A5);
    chk("wr_stb_cycles", 0, 64'(scyc[0]), 4);
    chk("wr_acks", 1, 64'(acode[1]), 1);
    wre_v = 3'b000;
    // watchdog timeout, then a normal retry
    ws = -1; sdata = 16'h1357; clr(); req(1, 1); wait_idle();
    chk("tmo_stb_cycles", 0, 64'(scyc[0]), 15);
    chk("tmo_errs", 0, 64'(ecode[0]), 2);
    chk("tmo_no_ack", 1, 64'(acode[1]), 0);
    ws = 0; clr(); req(1, 1); wait_idle();
    chk("retry_ack", 0, 64'(acode[0]), 2);
    chk("retry_dti", 1, 64'(dti[1]), 64'h1357);
    // reset mid-BUSY followed by stray acks
    ws = -1; clr(); req(1, 1);
    repeat (5) step();
    chk("busy_before_rst", 0, 64'(mstb[0]), 1);
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      stb[d] = 0;
      for (int i = 0; i < 3; i++) pend[d][i] = 0;
    end
    step();
    rst = 0; stray = 1;
    repeat (3) step();
    stray = 0;
    step();
    chk("rst_busy_stb", 0, 64'(mstb[0]), 0);
    chk("rst_stray_ack", 1, 64'(acode[1]), 0);
    chk("rst_dti_clear", 0, 64'(dti[0]), 0);
    chk("rst_ena_idle", 1, 64'(ena[1]), 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
